// File: rtl/obi_master_pipelined_if.sv
// OBI manager bundle: controller command/response port plus OBI A/R channels.
// The master modport is the manager's view; slave is the environment's view.
interface obi_master_pipelined_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int BW = DATA_WIDTH / 8;

  logic                  req_i;
  logic                  gnt_o;
  logic                  we_i;
  logic [BW-1:0]         be_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_we_o;
  logic                  spurious_o;
  logic                  obi_req_o;
  logic                  obi_gnt_i;
  logic [ADDR_WIDTH-1:0] obi_addr_o;
  logic                  obi_we_o;
  logic [BW-1:0]         obi_be_o;
  logic [DATA_WIDTH-1:0] obi_wdata_o;
  logic                  obi_rvalid_i;
  logic                  obi_rready_o;
  logic [DATA_WIDTH-1:0] obi_rdata_i;
  logic                  obi_err_i;

  modport master (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    input  rsp_ready_i,
    input  obi_gnt_i, obi_rvalid_i,
    input  obi_rdata_i, obi_err_i,
    output gnt_o,
    output rsp_valid_o, rsp_rdata_o,
    output rsp_err_o, rsp_we_o,
    output spurious_o,
    output obi_req_o, obi_addr_o, obi_we_o,
    output obi_be_o, obi_wdata_o,
    output obi_rready_o
  );

  modport slave (
    output req_i, we_i, be_i, addr_i, wdata_i,
    output rsp_ready_i,
    output obi_gnt_i, obi_rvalid_i,
    output obi_rdata_i, obi_err_i,
    input  gnt_o,
    input  rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o, rsp_we_o,
    input  spurious_o,
    input  obi_req_o, obi_addr_o, obi_we_o,
    input  obi_be_o, obi_wdata_o,
    input  obi_rready_o
  );
endinterface

// File: rtl/obi_master_pipelined.sv
// Pipelined OBI manager: registered A channel, in-order responses,
// up to MAX_OUTSTANDING transactions in flight.
module obi_master_pipelined #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  obi_master_pipelined_if.master bus
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                  a_valid_q;
  logic [ADDR_WIDTH-1:0] a_addr_q;
  logic                  a_we_q;
  logic [BW-1:0]         a_be_q;
  logic [DATA_WIDTH-1:0] a_wdata_q;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_we_q;
  logic                  spurious_q;

  logic gnt, accept, rready, r_fire, r_hs, r_spur;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_OUTSTANDING - 1)) ?
      '0 : p + PW'(1);
  endfunction

  // Grant depends only on state and obi_gnt_i, never on req_i.
  assign gnt    = (!a_valid_q || bus.obi_gnt_i) &&
                  (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept = bus.req_i && gnt;
  assign rready = !rsp_valid_q || bus.rsp_ready_i;
  assign r_fire = bus.obi_rvalid_i && rready;
  assign r_hs   = r_fire && (cnt_q != '0);
  assign r_spur = r_fire && (cnt_q == '0);

  assign bus.gnt_o        = gnt;
  assign bus.obi_req_o    = a_valid_q;
  assign bus.obi_addr_o   = a_addr_q;
  assign bus.obi_we_o     = a_we_q;
  assign bus.obi_be_o     = a_be_q;
  assign bus.obi_wdata_o  = a_wdata_q;
  assign bus.obi_rready_o = rready;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_rdata_o  = rsp_rdata_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.rsp_we_o     = rsp_we_q;
  assign bus.spurious_o   = spurious_q;

  // Next outstanding count and tag FIFO pointers.
  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = accept ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = r_hs ? ptr_inc(rptr_q) : rptr_q;
    unique case (1'b1)
      accept && !r_hs: cnt_d = cnt_q + CW'(1);
      r_hs && !accept: cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  // A-channel holding register, stable until granted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_we_q    <= 1'b0;
      a_be_q    <= '0;
      a_wdata_q <= '0;
    end else if (accept) begin
      a_valid_q <= 1'b1;
      a_addr_q  <= bus.addr_i;
      a_we_q    <= bus.we_i;
      a_be_q    <= bus.be_i;
      a_wdata_q <= bus.wdata_i;
    end else if (a_valid_q && bus.obi_gnt_i) begin
      a_valid_q <= 1'b0;
    end
  end

  // Outstanding count and we-tag FIFO.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fifo_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (accept) fifo_q[wptr_q] <= bus.we_i;
    end
  end

  // Response register and sticky spurious flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      if (r_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= bus.obi_rdata_i;
        rsp_err_q   <= bus.obi_err_i;
        rsp_we_q    <= fifo_q[rptr_q];
      end else if (bus.rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
      if (r_spur) spurious_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_master_pipelined.sv
// Directed bench for obi_master_pipelined.
// Inputs change 2ns after a rising edge; outputs sampled 1ns later.
module tb_obi_master_pipelined;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  obi_master_pipelined_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  obi_master_pipelined #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.req_i = 0; bus.we_i = 0; bus.be_i = 4'hF;
    bus.addr_i = 0; bus.wdata_i = 0; bus.rsp_ready_i = 1;
    bus.obi_gnt_i = 0; bus.obi_rvalid_i = 0;
    bus.obi_rdata_i = 0; bus.obi_err_i = 0;
    #12;
    chk("rst_req", bus.obi_req_o, 0);
    chk("rst_rready", bus.obi_rready_o, 1);
    chk("rst_rspv", bus.rsp_valid_o, 0);
    chk("rst_spur", bus.spurious_o, 0);
    chk("rst_addr", bus.obi_addr_o, 0);
    rst_n = 1;
    tick();

    // single read
    bus.req_i = 1; bus.addr_i = 32'h100; bus.obi_gnt_i = 1;
    settle();
    chk("rd_gnt", bus.gnt_o, 1);
    tick();
    bus.req_i = 0; settle();
    chk("rd_req", bus.obi_req_o, 1);
    chk("rd_addr", bus.obi_addr_o, 32'h100);
    chk("rd_be", bus.obi_be_o, 4'hF);
    chk("rd_we", bus.obi_we_o, 0);
    tick(); settle();
    chk("rd_req1", bus.obi_req_o, 0);
    tick();
    bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'hDEADBEEF;
    settle();
    chk("rd_rready", bus.obi_rready_o, 1);
    chk("rd_rsp0", bus.rsp_valid_o, 0);
    tick();
    bus.obi_rvalid_i = 0; settle();
    chk("rd_rspv", bus.rsp_valid_o, 1);
    chk("rd_data", bus.rsp_rdata_o, 32'hDEADBEEF);
    chk("rd_err", bus.rsp_err_o, 0);
    chk("rd_rwe", bus.rsp_we_o, 0);
    tick(); settle();
    chk("rd_rspv0", bus.rsp_valid_o, 0);

    // grant stall on a write
    bus.obi_gnt_i = 0;
    bus.req_i = 1; bus.we_i = 1; bus.addr_i = 32'h40;
    bus.wdata_i = 32'h12345678; bus.be_i = 4'h3;
    tick();
    bus.req_i = 0; bus.we_i = 0; bus.be_i = 4'hF;
    bus.addr_i = 0; bus.wdata_i = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.obi_gnt_i = 1;
      settle();
      chk($sformatf("st_req%0d", c), bus.obi_req_o, 1);
      chk($sformatf("st_addr%0d", c), bus.obi_addr_o, 32'h40);
      chk($sformatf("st_wd%0d", c), bus.obi_wdata_o, 32'h12345678);
      chk($sformatf("st_be%0d", c), bus.obi_be_o, 4'h3);
      chk($sformatf("st_we%0d", c), bus.obi_we_o, 1);
      chk($sformatf("st_gnt%0d", c), bus.gnt_o, (c == 5) ? 1 : 0);
      tick();
    end
    settle();
    chk("st_done", bus.obi_req_o, 0);
    bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'hCAFE;
    tick();
    bus.obi_rvalid_i = 0; settle();
    chk("wr_rspv", bus.rsp_valid_o, 1);
    chk("wr_rwe", bus.rsp_we_o, 1);
    chk("wr_data", bus.rsp_rdata_o, 32'hCAFE);
    tick();

    // four pipelined reads, fifth blocked by the outstanding limit
    bus.obi_gnt_i = 1;
    bus.req_i = 1;
    for (int i = 0; i < 4; i++) begin
      bus.addr_i = 32'h200 + 4 * i;
      settle();
      chk($sformatf("pl_gnt%0d", i), bus.gnt_o, 1);
      tick();
      settle();
      chk($sformatf("pl_req%0d", i), bus.obi_req_o, 1);
      chk($sformatf("pl_addr%0d", i), bus.obi_addr_o, 32'h200 + 4 * i);
    end
    bus.addr_i = 32'h210; settle();
    chk("pl_full", bus.gnt_o, 0);
    tick(); settle();
    chk("pl_full2", bus.gnt_o, 0);
    chk("pl_idle", bus.obi_req_o, 0);
    for (int k = 0; k < 5; k++) begin
      bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'hA0 + k;
      settle();
      if (k == 0) chk("pl_nogntyet", bus.gnt_o, 0);
      if (k == 1) chk("pl_gnt5", bus.gnt_o, 1);
      tick();
      if (k == 1) begin
        bus.req_i = 0; settle();
        chk("pl_req5", bus.obi_req_o, 1);
        chk("pl_addr5", bus.obi_addr_o, 32'h210);
      end
      settle();
      chk($sformatf("pl_rspv%0d", k), bus.rsp_valid_o, 1);
      chk($sformatf("pl_data%0d", k), bus.rsp_rdata_o, 32'hA0 + k);
    end
    bus.obi_rvalid_i = 0;
    tick(); settle();
    chk("pl_end", bus.rsp_valid_o, 0);

    // backpressure and error
    bus.req_i = 1; bus.addr_i = 32'h300;
    tick();
    bus.addr_i = 32'h304;
    tick();
    bus.req_i = 0;
    tick();
    bus.rsp_ready_i = 0;
    bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'hB0;
    settle();
    chk("bp_rr0", bus.obi_rready_o, 1);
    tick();
    bus.obi_rdata_i = 32'hB1; bus.obi_err_i = 1;
    settle();
    chk("bp_rr1", bus.obi_rready_o, 0);
    chk("bp_d0", bus.rsp_rdata_o, 32'hB0);
    chk("bp_e0", bus.rsp_err_o, 0);
    tick(); settle();
    chk("bp_hold", bus.rsp_rdata_o, 32'hB0);
    chk("bp_rr2", bus.obi_rready_o, 0);
    bus.rsp_ready_i = 1; settle();
    chk("bp_rr3", bus.obi_rready_o, 1);
    tick();
    bus.obi_rvalid_i = 0; bus.obi_err_i = 0; settle();
    chk("bp_d1", bus.rsp_rdata_o, 32'hB1);
    chk("bp_e1", bus.rsp_err_o, 1);
    chk("bp_v1", bus.rsp_valid_o, 1);
    tick(); settle();
    chk("bp_v0", bus.rsp_valid_o, 0);

    // spurious response, then reset mid-read
    bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'h5;
    tick();
    bus.obi_rvalid_i = 0; settle();
    chk("sp_rspv", bus.rsp_valid_o, 0);
    chk("sp_flag", bus.spurious_o, 1);
    bus.req_i = 1; bus.addr_i = 32'h400;
    tick();
    bus.req_i = 0; settle();
    chk("rr_req", bus.obi_req_o, 1);
    rst_n = 0; settle();
    chk("rr_req0", bus.obi_req_o, 0);
    chk("rr_addr0", bus.obi_addr_o, 0);
    chk("rr_spur0", bus.spurious_o, 0);
    chk("rr_rready", bus.obi_rready_o, 1);
    tick();
    rst_n = 1;
    tick();
    bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'h77;
    tick();
    bus.obi_rvalid_i = 0; settle();
    chk("rr_late_v", bus.rsp_valid_o, 0);
    chk("rr_late_sp", bus.spurious_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
